cmd_sequencer: RTL and testbench

- Drains the uCode command FIFO and assembles each command (one header word plus 0-3 payload words).
- Decodes the opcode and issues the command over a valid/ready handshake to one of three engine targets: fetch, dispatch, matmul.
- Executes the WAIT barrier opcode locally.
- Sits between cmd_fifo's read port and the GEMM engines, and is the only reader of that FIFO.

---
 rtl/gemm_pkg.sv | 41 ++++
 rtl/cmd_decode.sv | 33 +++
 rtl/cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// ---------------------------------------------------------------------------
// gemm_pkg
// Shared definitions for the GEMM command path: command word width, target
// and payload limits, the uCode opcode map, the header word layout and the
// command sequencer state encoding.
// ---------------------------------------------------------------------------
package gemm_pkg;

   // Width of one command word as it leaves cmd_fifo
   localparam int cmd_buf_width_gp = 32;

   // Engine targets: 0 fetch, 1 dispatch, 2 matmul
   localparam int NUM_TGT = 3;

   // Largest payload a header can announce (2-bit len field)
   localparam int MAX_PAY = 3;

   // Opcodes carried in header bits [7:0]
   localparam logic [7:0] OP_FETCH  = 8'hF0;
   localparam logic [7:0] OP_DISP   = 8'hF1;
   localparam logic [7:0] OP_MATMUL = 8'hF2;
   localparam logic [7:0] OP_WAIT   = 8'hF3;

   // Header word layout, LSB first: opcode, cmd_id, len, reserved
   typedef struct packed {
      logic [13:0] reserved;
      logic [1:0]  len;
      logic [7:0]  cmd_id;
      logic [7:0]  opcode;
   } cmd_hdr_t;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_HDR,
      SEQ_PAY,
      SEQ_DECODE,
      SEQ_ISSUE,
      SEQ_BARRIER
   } seq_state_e;

endpackage

// File: rtl/cmd_decode.sv
// ---------------------------------------------------------------------------
// cmd_decode
// Pure combinational opcode mapper, shared by the sequencer and by debug
// monitors that want the same view of a header.
//   i_opcode      header opcode byte
//   o_tgt_onehot  one-hot engine target for FETCH/DISP/MATMUL, else zero
//   o_is_wait     opcode is the WAIT barrier
//   o_illegal     opcode is none of the above
// ---------------------------------------------------------------------------
module cmd_decode
   import gemm_pkg::*;
(
   input  logic [7:0]         i_opcode,
   output logic [NUM_TGT-1:0] o_tgt_onehot,
   output logic               o_is_wait,
   output logic               o_illegal
);

   // Every opcode maps to exactly one of: a target, the barrier, or illegal
   always_comb begin
      o_tgt_onehot = '0;
      o_is_wait    = 1'b0;
      o_illegal    = 1'b0;
      unique case (i_opcode)
         OP_FETCH:  o_tgt_onehot = 3'b001;
         OP_DISP:   o_tgt_onehot = 3'b010;
         OP_MATMUL: o_tgt_onehot = 3'b100;
         OP_WAIT:   o_is_wait    = 1'b1;
         default:   o_illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/cmd_sequencer.sv
// ---------------------------------------------------------------------------
// cmd_sequencer
// Sole reader of cmd_fifo. Pulls one header plus 0-3 payload words, decodes
// the opcode and either hands the command to one engine over valid/ready,
// waits for all engines to go idle (WAIT), or drops it and flags an error.
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   o_fifo_rd_en       FIFO read strobe, data arrives the following cycle
//   i_fifo_rd_data     FIFO read data
//   i_fifo_empty       FIFO empty flag
//   o_tgt_valid        one-hot command valid per engine
//   i_tgt_ready        per-engine ready
//   o_cmd_data         header in word 0, payload k in word k+1, unused zero
//   i_tgt_idle         per-engine idle, consumed by WAIT
//   o_busy             any state other than IDLE
//   o_err              sticky unknown-opcode flag
//   o_cmd_count        retired commands (issued plus WAITs), wraps
//   o_err_count        dropped commands, saturates at 255
// ---------------------------------------------------------------------------
module cmd_sequencer
   import gemm_pkg::*;
#(
   parameter int NUM_TGT = gemm_pkg::NUM_TGT,
   parameter int MAX_PAY = gemm_pkg::MAX_PAY,
   parameter int W       = gemm_pkg::cmd_buf_width_gp
)
(
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   output logic                   o_fifo_rd_en,
   input  logic [W-1:0]           i_fifo_rd_data,
   input  logic                   i_fifo_empty,
   output logic [NUM_TGT-1:0]     o_tgt_valid,
   input  logic [NUM_TGT-1:0]     i_tgt_ready,
   output logic [W*(MAX_PAY+1)-1:0] o_cmd_data,
   input  logic [NUM_TGT-1:0]     i_tgt_idle,
   output logic                   o_busy,
   output logic                   o_err,
   output logic [15:0]            o_cmd_count,
   output logic [7:0]             o_err_count
);

   seq_state_e                 state_q, state_d;
   logic [W*(MAX_PAY+1)-1:0]   cmdBuf_q, cmdBuf_d;
   logic [1:0]                 reqCount_q, reqCount_d;
   logic [1:0]                 capCount_q, capCount_d;
   logic                       rdPending_q, rdPending_d;
   logic [NUM_TGT-1:0]         tgtValid_q, tgtValid_d;
   logic                       err_q, err_d;
   logic [15:0]                cmdCount_q, cmdCount_d;
   logic [7:0]                 errCount_q, errCount_d;

   logic                       rdEn;
   logic [1:0]                 lenIn;
   logic [1:0]                 lenHeld;
   logic [NUM_TGT-1:0]         decTgt;
   logic                       decWait;
   logic                       decIllegal;

   // In HDR the header is still on the read bus; afterwards it lives in word 0
   assign lenIn   = i_fifo_rd_data[17:16];
   assign lenHeld = cmdBuf_q[17:16];

   cmd_decode u_decode (
      .i_opcode     (cmdBuf_q[7:0]),
      .o_tgt_onehot (decTgt),
      .o_is_wait    (decWait),
      .o_illegal    (decIllegal)
   );

   // Read strobe: one header in IDLE, then payload words as fast as the FIFO
   // allows. The first payload read overlaps the header capture cycle, which
   // is what gets valid out at len+3 cycles after the header read.
   always_comb begin
      rdEn = 1'b0;
      unique case (state_q)
         SEQ_IDLE: rdEn = !i_fifo_empty;
         SEQ_HDR:  rdEn = !i_fifo_empty && (lenIn != 2'd0);
         SEQ_PAY:  rdEn = !i_fifo_empty && (reqCount_q < lenHeld);
         default:  rdEn = 1'b0;
      endcase
   end

   // Outputs are forced low while reset is held, including the strobe
   assign o_fifo_rd_en = rdEn && i_reset_n;
   assign o_tgt_valid  = tgtValid_q;
   assign o_cmd_data   = cmdBuf_q;
   assign o_busy       = (state_q != SEQ_IDLE);
   assign o_err        = err_q;
   assign o_cmd_count  = cmdCount_q;
   assign o_err_count  = errCount_q;

   // Next-state and datapath update. Valid is registered so it can only
   // change on a clock edge and is cleared together with the handshake.
   always_comb begin
      state_d     = state_q;
      cmdBuf_d    = cmdBuf_q;
      reqCount_d  = reqCount_q;
      capCount_d  = capCount_q;
      rdPending_d = rdEn;
      tgtValid_d  = tgtValid_q;
      err_d       = err_q;
      cmdCount_d  = cmdCount_q;
      errCount_d  = errCount_q;

      unique case (state_q)
         SEQ_IDLE: begin
            if (rdEn) begin
               state_d = SEQ_HDR;
            end
         end

         SEQ_HDR: begin
            cmdBuf_d        = '0;
            cmdBuf_d[W-1:0] = i_fifo_rd_data;
            capCount_d      = 2'd0;
            reqCount_d      = rdEn ? 2'd1 : 2'd0;
            state_d         = (lenIn == 2'd0) ? SEQ_DECODE : SEQ_PAY;
         end

         SEQ_PAY: begin
            if (rdEn) begin
               reqCount_d = reqCount_q + 2'd1;
            end
            if (rdPending_q) begin
               cmdBuf_d[W*(int'(capCount_q)+1) +: W] = i_fifo_rd_data;
               capCount_d = capCount_q + 2'd1;
               if (capCount_q == lenHeld - 2'd1) begin
                  state_d = SEQ_DECODE;
               end
            end
         end

         SEQ_DECODE: begin
            if (decIllegal) begin
               err_d = 1'b1;
               if (errCount_q != 8'hFF) begin
                  errCount_d = errCount_q + 8'd1;
               end
               state_d = SEQ_IDLE;
            end else if (decWait) begin
               state_d = SEQ_BARRIER;
            end else begin
               tgtValid_d = decTgt;
               state_d    = SEQ_ISSUE;
            end
         end

         SEQ_ISSUE: begin
            // Only the addressed engine's ready can complete the handshake
            if ((i_tgt_ready & tgtValid_q) != '0) begin
               tgtValid_d = '0;
               cmdCount_d = cmdCount_q + 16'd1;
               state_d    = SEQ_IDLE;
            end
         end

         SEQ_BARRIER: begin
            if (&i_tgt_idle) begin
               cmdCount_d = cmdCount_q + 16'd1;
               state_d    = SEQ_IDLE;
            end
         end

         default: state_d = SEQ_IDLE;
      endcase
   end

   // State register; reset drops any partial command
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= SEQ_IDLE;
         cmdBuf_q    <= '0;
         reqCount_q  <= 2'd0;
         capCount_q  <= 2'd0;
         rdPending_q <= 1'b0;
         tgtValid_q  <= '0;
         err_q       <= 1'b0;
         cmdCount_q  <= 16'd0;
         errCount_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         cmdBuf_q    <= cmdBuf_d;
         reqCount_q  <= reqCount_d;
         capCount_q  <= capCount_d;
         rdPending_q <= rdPending_d;
         tgtValid_q  <= tgtValid_d;
         err_q       <= err_d;
         cmdCount_q  <= cmdCount_d;
         errCount_q  <= errCount_d;
      end
   end

endmodule

// File: tb/tb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cmd_sequencer
// Directed bench for cmd_sequencer with a small queue-backed FIFO model.
// ---------------------------------------------------------------------------
module tb_cmd_sequencer;

   logic          clock;
   logic          resetN;
   logic          rdEn;
   logic [31:0]   rdData;
   logic          fifoEmpty;
   logic [2:0]    tgtValid;
   logic [2:0]    tgtReady;
   logic [127:0]  cmdData;
   logic [2:0]    tgtIdle;
   logic          busy;
   logic          err;
   logic [15:0]   cmdCount;
   logic [7:0]    errCount;

   logic [31:0]   fifoQ[$];
   int            readCount;
   int            assertCount;
   int            failCount;
   int            readsBefore;

   cmd_sequencer dut (
      .i_clk          (clock),
      .i_reset_n      (resetN),
      .o_fifo_rd_en   (rdEn),
      .i_fifo_rd_data (rdData),
      .i_fifo_empty   (fifoEmpty),
      .o_tgt_valid    (tgtValid),
      .i_tgt_ready    (tgtReady),
      .o_cmd_data     (cmdData),
      .i_tgt_idle     (tgtIdle),
      .o_busy         (busy),
      .o_err          (err),
      .o_cmd_count    (cmdCount),
      .o_err_count    (errCount)
   );

   // 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // FIFO model: data for a strobed read appears on the bus the next cycle
   always @(posedge clock) begin
      if (rdEn) begin
         readCount = readCount + 1;
         if (fifoQ.size() > 0) begin
            rdData <= fifoQ.pop_front();
         end
         fifoEmpty <= (fifoQ.size() == 0);
      end
   end

   // The sequencer must never strobe an empty FIFO
   always @(negedge clock) begin
      if (resetN) begin
         checkOutput("noRdWhileEmpty", {127'd0, rdEn & fifoEmpty}, 128'd0);
      end
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] word);
      fifoQ.push_back(word);
      fifoEmpty = 1'b0;
   endtask

   // Leaves the caller 1 ns after the negedge of the cycle that strobes rd_en
   task automatic waitForRdEn(input string tag);
      int n = 0;
      #1;
      while (!rdEn && n < 40) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (!rdEn) checkOutput(tag, 128'd0, 128'd1);
   endtask

   task automatic waitForValid(input string tag);
      int n = 0;
      #1;
      while (tgtValid == 3'b000 && n < 40) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (tgtValid == 3'b000) checkOutput(tag, 128'd0, 128'd1);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      readCount   = 0;
      fifoEmpty   = 1'b1;
      rdData      = 32'd0;
      tgtReady    = 3'b111;
      tgtIdle     = 3'b111;
      resetN      = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      checkOutput("rstValid",    {125'd0, tgtValid}, 128'd0);
      checkOutput("rstBusy",     {127'd0, busy},     128'd0);
      checkOutput("rstCmdCount", {112'd0, cmdCount}, 128'd0);
      checkOutput("rstData",     cmdData,            128'd0);
      checkOutput("rstRdEn",     {127'd0, rdEn},     128'd0);

      // FETCH with two payload words, valid at cycle len+3 = 5
      applyStimulus(32'h000201F0);
      applyStimulus(32'hAAAA0001);
      applyStimulus(32'hBBBB0002);
      resetN = 1'b1;
      waitForRdEn("t1RdTimeout");
      repeat (4) @(negedge clock);
      checkOutput("t1ValidEarly", {125'd0, tgtValid}, 128'd0);
      @(negedge clock);
      checkOutput("t1Valid", {125'd0, tgtValid}, {125'd0, 3'b001});
      checkOutput("t1Data", cmdData, {32'h0, 32'hBBBB0002, 32'hAAAA0001, 32'h000201F0});
      @(negedge clock);
      checkOutput("t1ValidDrop", {125'd0, tgtValid}, 128'd0);
      checkOutput("t1CmdCount",  {112'd0, cmdCount}, 128'd1);
      checkOutput("t1Busy",      {127'd0, busy},     128'd0);

      // MATMUL held off by its own ready; other readies must be ignored
      tgtReady = 3'b000;
      applyStimulus(32'h000003F2);
      waitForRdEn("t2RdTimeout");
      repeat (3) @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         checkOutput("t2Valid", {125'd0, tgtValid}, {125'd0, 3'b100});
         checkOutput("t2Data",  cmdData, {96'h0, 32'h000003F2});
         #1;
         tgtReady = (i == 2) ? 3'b001 : (i == 5) ? 3'b010 : 3'b000;
         @(negedge clock);
      end
      tgtReady = 3'b100;
      @(negedge clock);
      checkOutput("t2ValidDrop", {125'd0, tgtValid}, 128'd0);
      checkOutput("t2CmdCount",  {112'd0, cmdCount}, 128'd2);
      tgtReady = 3'b111;

      // DISP whose payload shows up six cycles after the header
      applyStimulus(32'h000101F1);
      waitForRdEn("t3RdTimeout");
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         checkOutput("t3NoValid", {125'd0, tgtValid}, 128'd0);
      end
      checkOutput("t3BusyStall", {127'd0, busy}, 128'd1);
      applyStimulus(32'hCCCC0003);
      waitForValid("t3ValidTimeout");
      checkOutput("t3Valid", {125'd0, tgtValid}, {125'd0, 3'b010});
      checkOutput("t3Data",  cmdData, {64'h0, 32'hCCCC0003, 32'h000101F1});
      @(negedge clock);
      checkOutput("t3CmdCount", {112'd0, cmdCount}, 128'd3);

      // Illegal opcode with one payload word, then a FETCH that must stay aligned
      applyStimulus(32'h00010055);
      applyStimulus(32'h12345678);
      applyStimulus(32'h000000F0);
      waitForValid("t4ValidTimeout");
      checkOutput("t4Valid",    {125'd0, tgtValid}, {125'd0, 3'b001});
      checkOutput("t4Data",     cmdData, {96'h0, 32'h000000F0});
      checkOutput("t4Err",      {127'd0, err},      128'd1);
      checkOutput("t4ErrCount", {120'd0, errCount}, 128'd1);
      @(negedge clock);
      checkOutput("t4CmdCount", {112'd0, cmdCount}, 128'd4);

      // WAIT blocks the following FETCH until every engine is idle
      tgtIdle = 3'b011;
      applyStimulus(32'h000000F3);
      applyStimulus(32'h000000F0);
      waitForRdEn("t5RdTimeout");
      readsBefore = readCount;
      repeat (20) @(negedge clock);
      checkOutput("t5OneRead",  readCount - readsBefore, 128'd1);
      checkOutput("t5CmdCount", {112'd0, cmdCount}, 128'd4);
      checkOutput("t5Busy",     {127'd0, busy},     128'd1);
      checkOutput("t5NoValid",  {125'd0, tgtValid}, 128'd0);
      #1;
      tgtIdle = 3'b111;
      @(negedge clock);
      checkOutput("t5WaitRetired", {112'd0, cmdCount}, 128'd5);
      checkOutput("t5RdAfterWait", {127'd0, rdEn},     128'd1);
      waitForValid("t5ValidTimeout");
      checkOutput("t5Valid", {125'd0, tgtValid}, {125'd0, 3'b001});
      @(negedge clock);
      checkOutput("t5FetchRetired", {112'd0, cmdCount}, 128'd6);

      // Asynchronous reset while a command sits in ISSUE
      tgtReady = 3'b000;
      applyStimulus(32'h000003F2);
      waitForValid("t6ValidTimeout");
      #1;
      resetN = 1'b0;
      #1;
      checkOutput("t6Valid",    {125'd0, tgtValid}, 128'd0);
      checkOutput("t6Busy",     {127'd0, busy},     128'd0);
      checkOutput("t6CmdCount", {112'd0, cmdCount}, 128'd0);
      checkOutput("t6ErrCount", {120'd0, errCount}, 128'd0);
      checkOutput("t6Err",      {127'd0, err},      128'd0);
      checkOutput("t6Data",     cmdData,            128'd0);
      repeat (2) @(negedge clock);
      resetN   = 1'b1;
      tgtReady = 3'b111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput("t6NoRdEn",    {127'd0, rdEn},     128'd0);
         checkOutput("t6IdleBusy",  {127'd0, busy},     128'd0);
         checkOutput("t6IdleValid", {125'd0, tgtValid}, 128'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
